// File: rtl/rf_vec_add_seq_if.sv
// Register-file access bus used by rf_vec_add_seq.
// Two combinational read ports plus one synchronous write port.
// The sequencer uses the master modport; the register file uses the slave modport.
interface rf_vec_add_seq_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] rf_raddr1;
  logic [AW-1:0] rf_raddr2;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata,
    input  rf_rdata1, rf_rdata2
  );

  modport slave (
    input  rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata,
    output rf_rdata1, rf_rdata2
  );
endinterface

// File: rtl/rf_vec_add_seq.sv
// rf_vec_add_seq: multi-cycle element-wise vector add over a 2**AW-entry register file.
//   R[dst+i] = R[src1+i] + R[src2+i] for i = 0..count-1, all addresses modulo 2**AW.
// Each element takes one READ cycle followed by one WRITE cycle. The write therefore
// commits before the next element is read, so overlapping vectors behave sequentially.
// Optional build macro RF_VEC_SAT_EN: when defined, a result whose addition carries out
// is written as all ones instead of the wrapped sum. carry_any is the same in both builds.
module rf_vec_add_seq #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [AW-1:0]       src1,
  input  logic [AW-1:0]       src2,
  input  logic [AW-1:0]       dst,
  input  logic [AW:0]         count,
  rf_vec_add_seq_if.master    rf,
  output logic                busy,
  output logic                done,
  output logic                carry_any,
  output logic [AW:0]         elem_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Operation parameters captured at accept, so later input changes have no effect.
  logic [AW-1:0] src1_reg, src2_reg, dst_reg;
  logic [AW:0]   count_reg;

  logic [AW:0]   elem_idx_reg;
  logic          carry_any_reg;
  logic [DW-1:0] wdata_reg;

  logic [AW-1:0] idx_lo;
  logic          accept;
  logic          last_elem;
  logic [DW:0]   add_full;
  logic [DW-1:0] sum_next;

  // Only the low AW bits of the index matter for addressing: this gives the modulo wrap.
  assign idx_lo    = elem_idx_reg[AW-1:0];
  assign accept    = (state_reg == S_IDLE) && start;
  assign last_elem = ((elem_idx_reg + {{AW{1'b0}}, 1'b1}) == count_reg);
  assign add_full  = {1'b0, rf.rf_rdata1} + {1'b0, rf.rf_rdata2};

`ifdef RF_VEC_SAT_EN
  assign sum_next = add_full[DW] ? {DW{1'b1}} : add_full[DW-1:0];
`else
  assign sum_next = add_full[DW-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_next = S_WRITE;
      S_WRITE: state_next = last_elem ? S_DONE : S_READ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture at accept, sum capture in READ, index step in WRITE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src1_reg      <= '0;
      src2_reg      <= '0;
      dst_reg       <= '0;
      count_reg     <= '0;
      elem_idx_reg  <= '0;
      carry_any_reg <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      if (accept) begin
        src1_reg      <= src1;
        src2_reg      <= src2;
        dst_reg       <= dst;
        count_reg     <= count;
        elem_idx_reg  <= '0;
        carry_any_reg <= 1'b0;
      end
      if (state_reg == S_READ) begin
        wdata_reg     <= sum_next;
        carry_any_reg <= carry_any_reg | add_full[DW];
      end
      if (state_reg == S_WRITE) begin
        elem_idx_reg <= elem_idx_reg + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Output decode from the current state; addresses are zero outside the state using them.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    rf.rf_wen    = 1'b0;
    rf.rf_raddr1 = '0;
    rf.rf_raddr2 = '0;
    rf.rf_waddr  = '0;
    case (state_reg)
      S_READ: begin
        busy         = 1'b1;
        rf.rf_raddr1 = src1_reg + idx_lo;
        rf.rf_raddr2 = src2_reg + idx_lo;
      end
      S_WRITE: begin
        busy        = 1'b1;
        rf.rf_wen   = 1'b1;
        rf.rf_waddr = dst_reg + idx_lo;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign rf.rf_wdata = wdata_reg;
  assign carry_any   = carry_any_reg;
  assign elem_idx    = elem_idx_reg;

endmodule

// File: tb/tb_rf_vec_add_seq.sv
// Testbench for rf_vec_add_seq: register-file slave, write monitor and a vector-add model.
// Honours RF_VEC_SAT_EN the same way as the design when the macro is defined.
module tb_rf_vec_add_seq;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] src1, src2, dst;
  logic [AW:0]   count;
  logic          busy, done, carry_any;
  logic [AW:0]   elem_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_vec_add_seq_if #(.DW(DW), .AW(AW)) rf_bus ();

  rf_vec_add_seq #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src1      (src1),
    .src2      (src2),
    .dst       (dst),
    .count     (count),
    .rf        (rf_bus),
    .busy      (busy),
    .done      (done),
    .carry_any (carry_any),
    .elem_idx  (elem_idx)
  );

  // Register file: combinational reads, write on the clock edge, bulk preload from the bench.
  logic [DW-1:0] mem     [N];
  logic [DW-1:0] pre_mem [N];
  logic [DW-1:0] ref_mem [N];
  logic          pre_load = 1'b0;

  assign rf_bus.rf_rdata1 = mem[rf_bus.rf_raddr1];
  assign rf_bus.rf_rdata2 = mem[rf_bus.rf_raddr2];

  always @(posedge clk) begin
    if (pre_load) mem <= pre_mem;
    else if (rf_bus.rf_wen === 1'b1) mem[rf_bus.rf_waddr] <= rf_bus.rf_wdata;
  end

  // Write monitor, sampled mid-cycle.
  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  always @(negedge clk) begin
    if (rf_bus.rf_wen === 1'b1) begin
      wq_addr.push_back(rf_bus.rf_waddr);
      wq_data.push_back(rf_bus.rf_wdata);
    end
  end

  // Expected results of the current operation.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_carry;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Vector add straight from the definition; only the first lim results are committed.
  task automatic model_op(input int s1, input int s2, input int d, input int cnt, input int lim);
    longint unsigned a, b, s;
    logic [DW-1:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_carry = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      a = 64'(ref_mem[(s1 + i) % N]);
      b = 64'(ref_mem[(s2 + i) % N]);
      s = a + b;
      w = s[DW-1:0];
      if (s > 64'hFFFF_FFFF) begin
        exp_carry = 1'b1;
`ifdef RF_VEC_SAT_EN
        w = '1;
`endif
      end
      if (i < lim) begin
        ref_mem[(d + i) % N] = w;
        exp_addr.push_back(AW'((d + i) % N));
        exp_data.push_back(w);
      end
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    pre_load = 1'b1;
    @(negedge clk);
    pre_load = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = pre_mem[i];
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (!rnd) pre_mem[i] = '0;
      else if ($urandom_range(0, 1) == 1) pre_mem[i] = 32'hF000_0000 | $urandom;
      else pre_mem[i] = $urandom;
    end
  endtask

  task automatic check_writes(input string name);
    int diffs;
    check({name, "_nwrites"}, 64'(wq_addr.size()), 64'(exp_addr.size()));
    foreach (exp_addr[i]) begin
      if (i < wq_addr.size()) begin
        check({name, "_waddr"}, 64'(wq_addr[i]), 64'(exp_addr[i]));
        check({name, "_wdata"}, 64'(wq_data[i]), 64'(exp_data[i]));
      end
    end
    diffs = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check({name, "_mem"}, 64'(diffs), 64'd0);
  endtask

  // One full operation; poke re-asserts start with other operands while busy.
  task automatic run_op(input string name, input int s1, input int s2, input int d,
                        input int cnt, input bit poke);
    int lat;
    model_op(s1, s2, d, cnt, cnt);
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    start = 1'b1;
    src1  = AW'(s1);
    src2  = AW'(s2);
    dst   = AW'(d);
    count = (AW+1)'(cnt);
    lat   = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check({name, "_busy_run"}, 64'(busy), 64'd1);
      end
      if (poke && k == 2) begin
        start = 1'b1;
        src1  = AW'($urandom);
        src2  = AW'($urandom);
        dst   = AW'($urandom);
        count = 6'd2;
      end
      if (poke && k == 3) start = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(2 * cnt + 1));
    @(negedge clk);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_done_after"}, 64'(done), 64'd0);
    check({name, "_carry_any"}, 64'(carry_any), 64'(exp_carry));
    check({name, "_elem_idx"}, 64'(elem_idx), 64'(cnt));
    check_writes(name);
    $display("op %s src1=%0d src2=%0d dst=%0d count=%0d latency=%0d writes=%0d carry_any=%0d",
             name, s1, s2, d, cnt, lat, wq_addr.size(), carry_any);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    src1   = '0;
    src2   = '0;
    dst    = '0;
    count  = '0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wen", 64'(rf_bus.rf_wen), 64'd0);
    check("rst_raddr1", 64'(rf_bus.rf_raddr1), 64'd0);
    check("rst_raddr2", 64'(rf_bus.rf_raddr2), 64'd0);
    check("rst_waddr", 64'(rf_bus.rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_bus.rf_wdata), 64'd0);
    check("rst_carry_any", 64'(carry_any), 64'd0);
    check("rst_elem_idx", 64'(elem_idx), 64'd0);
    resetn = 1'b1;
    $display("reset released");

    // Simple add, then a carrying add at the same addresses.
    fill(1'b0);
    pre_mem[1] = 32'd5;
    pre_mem[2] = 32'd7;
    load_mem();
    run_op("basic", 1, 2, 3, 1, 1'b0);
    pre_mem[1] = 32'hFFFF_FFFF;
    pre_mem[2] = 32'd2;
    load_mem();
    run_op("carry", 1, 2, 3, 1, 1'b0);

    // Address wrap 31 -> 0 with an in-place destination.
    fill(1'b0);
    pre_mem[30] = 32'd1;
    pre_mem[31] = 32'd2;
    pre_mem[0]  = 32'd3;
    pre_mem[1]  = 32'd10;
    pre_mem[2]  = 32'd10;
    pre_mem[3]  = 32'd10;
    load_mem();
    run_op("wrap", 30, 1, 30, 3, 1'b0);

    // Prefix chain: each element consumes the previous result.
    fill(1'b0);
    pre_mem[0] = 32'd1;
    load_mem();
    run_op("chain", 0, 1, 1, 4, 1'b0);

    // Empty operation, then a run with a second start while busy.
    run_op("count0", 7, 8, 9, 0, 1'b0);
    fill(1'b1);
    load_mem();
    run_op("busy_start", 3, 12, 20, 5, 1'b1);

    // Reset in the third cycle of a count=4 run whose first element carries.
    fill(1'b1);
    for (int i = 0; i < N; i++) pre_mem[i] = 32'hF000_0000 | pre_mem[i];
    load_mem();
    model_op(4, 9, 20, 4, 1);
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    start = 1'b1;
    src1  = 5'd4;
    src2  = 5'd9;
    dst   = 5'd20;
    count = 6'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst_carry_before", 64'(carry_any), 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_wen", 64'(rf_bus.rf_wen), 64'd0);
    check("midrst_elem_idx", 64'(elem_idx), 64'd0);
    check("midrst_carry_any", 64'(carry_any), 64'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_writes("midrst");
    $display("op midrst src1=4 src2=9 dst=20 count=4 writes=%0d", wq_addr.size());
    run_op("after_rst", 6, 6, 6, 3, 1'b0);

    // Full-file operation and randomized operations.
    fill(1'b1);
    load_mem();
    run_op("full32", 17, 2, 9, 32, 1'b0);
    for (int t = 0; t < 12; t++) begin
      fill(1'b1);
      load_mem();
      run_op("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
